// File: rtl/ram_dados_resp.sv
// ram_dados_resp: load/store data memory with req/ready handshake, wait states and RV32I sub-word access
module ram_dados_resp #(
    parameter int LATENCIA      = 2,
    parameter int PALAVRAS_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);
    typedef enum logic [1:0] {OCIOSO, ESPERA, RESPOSTA} estado_t;
    estado_t estado, prox;
    logic [3:0] cnt;
    logic we_q;
    logic [PALAVRAS_LOG2+1:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0] f3_q;
    logic [31:0] mem [2**PALAVRAS_LOG2];
    logic [31:0] rdata_q;
    logic err_q;
    logic [PALAVRAS_LOG2-1:0] idx;
    logic [1:0] lane;
    logic acesso, rej;
    logic [31:0] palavra, wd, ld;
    logic [7:0] b;
    logic [15:0] h;
    logic [3:0] be;
    always_ff @(posedge clk or negedge rst)
        if (!rst) estado <= OCIOSO;
        else estado <= prox;
    always_comb
        prox = estado == OCIOSO ? (req ? ESPERA : OCIOSO) :
               estado == ESPERA ? (cnt == 4'd0 ? RESPOSTA : ESPERA) : OCIOSO;
    always_comb begin
        ready = estado == RESPOSTA;
        rdata = ready ? rdata_q : 32'd0;
        err   = ready & err_q;
    end
    always_comb begin
        acesso  = estado == ESPERA && cnt == 4'd0;
        idx     = addr_q[PALAVRAS_LOG2+1:2];
        lane    = addr_q[1:0];
        palavra = mem[idx];
        b       = palavra[8*lane +: 8];
        h       = lane[1] ? palavra[31:16] : palavra[15:0];
        ld      = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & b[7]}}, b} :
                  f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & h[15]}}, h} : palavra;
        rej     = (we_q ? f3_q > 3'd2 : (f3_q[1:0] == 2'b11 || f3_q == 3'b110)) ||
                  (f3_q[1:0] == 2'b01 && lane[0]) || (f3_q[1:0] == 2'b10 && lane != 2'd0);
        wd      = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                  f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
        be      = f3_q[1:0] == 2'b00 ? 4'b0001 << lane :
                  f3_q[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (estado == OCIOSO && req) begin
                cnt     <= 4'(LATENCIA);
                we_q    <= we;
                addr_q  <= addr[PALAVRAS_LOG2+1:0];
                wdata_q <= wdata;
                f3_q    <= funct3;
            end else if (estado == ESPERA && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (acesso) begin
                rdata_q <= (rej || we_q) ? 32'd0 : ld;
                err_q   <= rej;
            end
        end
    // Array is deliberately left out of reset; only a completed, legal store touches it.
    always_ff @(posedge clk)
        if (acesso && we_q && !rej)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
endmodule
